// File: rtl/mux_arb_pkg.sv
// Shared constants, lock-state encoding and pointer helper for the N:1 arbitrating mux.
package mux_arb_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] ptr,
    input  logic                    en,
    output logic [N_CH-1:0]         grant
);

    logic [2*N_CH-1:0] dbl_req;
    logic [2*N_CH-1:0] mask;
    logic [2*N_CH-1:0] masked;
    logic              found;

    // The upper copy is never masked, so a search past the top wraps to the low channels.
    always_comb begin
        dbl_req = {req, req};
        mask    = '0;
        for (int i = 0; i < 2*N_CH; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = dbl_req & mask;
        grant  = '0;
        found  = 1'b0;
        for (int i = 0; i < 2*N_CH; i++) begin
            if (en && !found && masked[i]) begin
                grant[i % N_CH] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-channel registered mux with valid/ready handshakes, external or round-robin selection
// and optional packet lock held from the first beat until in_last.
module mux_arb_nto1
    import mux_arb_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int W        = 8,
    parameter int MODE     = 1,
    parameter int PKT_LOCK = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(N_CH)-1:0] sel,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*W-1:0]       in_data,
    input  logic [N_CH-1:0]         in_last,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic                    out_last,
    output logic [$clog2(N_CH)-1:0] out_ch,
    input  logic                    out_ready
);

    localparam int PW = $clog2(N_CH);

    lock_state_e   state_q, state_d;
    logic [PW-1:0] lock_ch_q, lock_ch_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [PW-1:0] out_ch_q, out_ch_d;

    logic            load;
    logic            locked;
    logic [N_CH-1:0] lock_mask;
    logic [N_CH-1:0] rr_req;
    logic [N_CH-1:0] rr_gnt;
    logic [N_CH-1:0] sel_gnt;
    logic [N_CH-1:0] gnt;
    logic [N_CH-1:0] xfer_oh;
    logic            xfer;
    logic [W-1:0]    mux_data;
    logic            mux_last;
    logic [PW-1:0]   xfer_idx;

    assign load   = !out_valid_q || out_ready;
    assign locked = (PKT_LOCK != 0) && (state_q == ST_LOCKED);

    // While a packet is open only its channel may compete, regardless of sel or pointer.
    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_ch_q] = 1'b1;
        rr_req               = locked ? (in_valid & lock_mask) : in_valid;
        sel_gnt              = '0;
        if (locked) begin
            sel_gnt = in_valid & lock_mask;
        end else if (32'(sel) < N_CH && in_valid[sel]) begin
            sel_gnt[sel] = 1'b1;
        end
    end

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr_arbiter (
        .req   (rr_req),
        .ptr   (rr_ptr_q),
        .en    (load),
        .grant (rr_gnt)
    );

    assign gnt      = (MODE == MODE_RR) ? rr_gnt : sel_gnt;
    assign in_ready = gnt & {N_CH{load & rst_n}};
    assign xfer_oh  = in_ready & in_valid;
    assign xfer     = |xfer_oh;

    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        xfer_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            mux_data = mux_data | (in_data[i*W +: W] & {W{xfer_oh[i]}});
            mux_last = mux_last | (in_last[i] & xfer_oh[i]);
            if (xfer_oh[i]) begin
                xfer_idx = PW'(i);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_last_d  = mux_last;
            out_ch_d    = xfer_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // The pointer only moves at a packet boundary so a locked packet does not skew fairness.
        if (xfer && (mux_last || PKT_LOCK == 0)) begin
            rr_ptr_d = PW'(next_ptr(32'(xfer_idx), N_CH));
        end
        if (xfer && PKT_LOCK != 0) begin
            if (mux_last) begin
                state_d = ST_IDLE;
            end else begin
                state_d   = ST_LOCKED;
                lock_ch_d = xfer_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: three configurations (RR+lock, RR per-beat, SEL+lock) share stimulus
// and are compared against a channel-search reference model plus directed expectations.
module tb_mux_arb_nto1;

    localparam int N = 4;
    localparam int W = 8;
    localparam int K = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   sel = '0;
    logic [N-1:0] in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0] in_last = '0;
    logic         out_ready = 1'b0;

    logic [N-1:0] rdy_a [K];
    logic         ov_a  [K];
    logic [W-1:0] od_a  [K];
    logic         ol_a  [K];
    logic [1:0]   oc_a  [K];

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state, one entry per configuration
    int       m_mode [K] = '{1, 1, 0};
    int       m_lk   [K] = '{1, 0, 1};
    bit       m_ov   [K];
    logic [7:0] m_data [K];
    bit       m_last [K];
    int       m_ch   [K];
    int       m_ptr  [K];
    bit       m_lckd [K];
    int       m_lch  [K];
    int       m_gnt  [K];

    int t3_exp [5] = '{2, 2, 2, 3, 0};

    always #5 clk = ~clk;

    mux_arb_nto1 #(.N_CH(N), .W(W), .MODE(1), .PKT_LOCK(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_a[0]), .out_valid(ov_a[0]), .out_data(od_a[0]),
        .out_last(ol_a[0]), .out_ch(oc_a[0]), .out_ready(out_ready));

    mux_arb_nto1 #(.N_CH(N), .W(W), .MODE(1), .PKT_LOCK(0)) dut_nl (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_a[1]), .out_valid(ov_a[1]), .out_data(od_a[1]),
        .out_last(ol_a[1]), .out_ch(oc_a[1]), .out_ready(out_ready));

    mux_arb_nto1 #(.N_CH(N), .W(W), .MODE(0), .PKT_LOCK(1)) dut_sel (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_a[2]), .out_valid(ov_a[2]), .out_data(od_a[2]),
        .out_last(ol_a[2]), .out_ch(oc_a[2]), .out_ready(out_ready));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < K; k++) begin
            m_ov[k] = 0; m_data[k] = '0; m_last[k] = 0; m_ch[k] = 0;
            m_ptr[k] = 0; m_lckd[k] = 0; m_lch[k] = 0; m_gnt[k] = -1;
        end
    endtask

    // Which channel each configuration should accept this cycle (-1 = none).
    task automatic model_comb();
        for (int k = 0; k < K; k++) begin
            bit found;
            m_gnt[k] = -1;
            found = 0;
            if (rst_n && (!m_ov[k] || out_ready)) begin
                if (m_lckd[k]) begin
                    if (in_valid[m_lch[k]]) m_gnt[k] = m_lch[k];
                end else if (m_mode[k] == 0) begin
                    if (in_valid[sel]) m_gnt[k] = int'(sel);
                end else begin
                    for (int j = 0; j < N; j++) begin
                        int c;
                        c = (m_ptr[k] + j) % N;
                        if (!found && in_valid[c]) begin
                            m_gnt[k] = c;
                            found = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < K; k++) begin
            int g;
            g = m_gnt[k];
            if (g >= 0) begin
                m_ov[k] = 1;
                m_data[k] = in_data[g*W +: W];
                m_last[k] = in_last[g];
                m_ch[k] = g;
                if (m_last[k] || m_lk[k] == 0) m_ptr[k] = (g + 1) % N;
                if (m_lk[k] != 0) begin
                    m_lckd[k] = !m_last[k];
                    m_lch[k] = g;
                end
            end else if (out_ready) begin
                m_ov[k] = 0;
            end
        end
    endtask

    task automatic check_ready();
        for (int k = 0; k < K; k++) begin
            logic [N-1:0] e;
            e = (m_gnt[k] >= 0) ? N'(1 << m_gnt[k]) : '0;
            chk($sformatf("in_ready%0d", k), 32'(rdy_a[k]), 32'(e));
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < K; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(ov_a[k]), 32'(m_ov[k]));
            chk($sformatf("out_data%0d", k), 32'(od_a[k]), 32'(m_data[k]));
            chk($sformatf("out_last%0d", k), 32'(ol_a[k]), 32'(m_last[k]));
            chk($sformatf("out_ch%0d", k), 32'(oc_a[k]), 32'(m_ch[k]));
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        #1;
        model_comb();
        check_ready();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        for (int k = 0; k < K; k++) chk($sformatf("rst_ready%0d", k), 32'(rdy_a[k]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // reset with every channel valid, then first beat one clock after the first grant
        set_default_data();
        in_valid = 4'hF; in_last = 4'h0; out_ready = 1'b1;
        do_reset();

        // round-robin fairness on the per-beat configuration
        for (int b = 0; b < 6; b++) begin
            cycle();
            chk("t2_valid", 32'(ov_a[1]), 32'h1);
            chk("t2_ch", 32'(oc_a[1]), 32'(b % 4));
            chk("t2_data", 32'(od_a[1]), 32'(8'hA0 + 8'(b % 4)));
        end

        // three-beat packet on ch2 holds the grant while ch0/ch3 wait
        do_reset();
        in_last = 4'b1001;
        for (int b = 0; b < 5; b++) begin
            in_valid = (b == 0) ? 4'b0100 : (b < 3) ? 4'b1101 : 4'b1001;
            in_last[2] = (b == 2);
            cycle();
            chk("t3_ch", 32'(oc_a[0]), 32'(t3_exp[b]));
        end

        // backpressure for five clocks, then release
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            #1 chk("t4_ready", 32'(rdy_a[0]), 32'h0);
            cycle();
        end
        out_ready = 1'b1;
        cycle();

        // SEL mode: invalid selection, valid selection, sel change mid-packet
        do_reset();
        in_last = 4'h0; sel = 2'd1; in_valid = 4'b0101;
        #1 chk("t5_noready", 32'(rdy_a[2]), 32'h0);
        cycle();
        sel = 2'd2;
        #1 chk("t5_ready", 32'(rdy_a[2]), 32'h4);
        cycle();
        chk("t5_ch_a", 32'(oc_a[2]), 32'h2);
        sel = 2'd0;
        cycle();
        chk("t5_ch_b", 32'(oc_a[2]), 32'h2);
        in_last[2] = 1'b1;
        cycle();
        chk("t5_ch_c", 32'(oc_a[2]), 32'h2);
        in_last = 4'h0;
        cycle();
        chk("t5_ch_d", 32'(oc_a[2]), 32'h0);

        // reset while locked on ch1, then ch0 wins first
        do_reset();
        sel = 2'd1; in_valid = 4'b0010; in_last = 4'h0;
        cycle();
        cycle();
        chk("t6_ch_pre", 32'(oc_a[0]), 32'h1);
        do_reset();
        chk("t6_valid_rst", 32'(ov_a[0]), 32'h0);
        in_valid = 4'hF; in_last = 4'hF;
        cycle();
        chk("t6_valid", 32'(ov_a[0]), 32'h1);
        chk("t6_ch", 32'(oc_a[0]), 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            in_valid = N'($urandom());
            in_data = $urandom();
            for (int i = 0; i < N; i++) in_last[i] = ($urandom_range(0, 99) < 35);
            sel = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
